// File: rtl/fdtd_pkg.sv
// Shared types for the FDTD sweep controller: sequencer states and field-phase encoding.
package fdtd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fdtd_state_e;

  localparam logic PHASE_E = 1'b0;
  localparam logic PHASE_H = 1'b1;

endpackage

// File: rtl/fdtd_valid_pipe.sv
// Fixed-latency shadow of the arithmetic pipeline: shifts {valid, addr, phase} every cycle,
// flushes synchronously, and reports when nothing beyond the current output stage is in flight.
module fdtd_valid_pipe #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          in_valid_i,
  input  logic [AW-1:0] in_addr_i,
  input  logic          in_phase_i,
  output logic          out_valid_o,
  output logic [AW-1:0] out_addr_o,
  output logic          out_phase_o,
  output logic          empty_o
);

  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [DEPTH-1:0]         ph_q, ph_d;
  logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;

  logic [DEPTH:0]           vld_chain;
  logic [DEPTH:0]           ph_chain;
  logic [DEPTH:0][AW-1:0]   addr_chain;

  assign vld_chain  = {vld_q, in_valid_i};
  assign ph_chain   = {ph_q, in_phase_i};
  assign addr_chain = {addr_q, in_addr_i};

  always_comb begin
    vld_d  = vld_chain[DEPTH-1:0];
    ph_d   = ph_chain[DEPTH-1:0];
    addr_d = addr_chain[DEPTH-1:0];
    if (flush_i) vld_d = '0;
  end

  // The output stage is the write happening this cycle, so it does not count as in flight.
  always_comb begin
    empty_o = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (vld_q[i]) empty_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      ph_q   <= '0;
      addr_q <= '0;
    end else begin
      vld_q  <= vld_d;
      ph_q   <= ph_d;
      addr_q <= addr_d;
    end
  end

  assign out_valid_o = vld_q[DEPTH-1];
  assign out_addr_o  = addr_q[DEPTH-1];
  assign out_phase_o = ph_q[DEPTH-1];

endmodule

// File: rtl/fdtd_sweep_ctrl.sv
// FDTD sweep sequencer: E then H sweep per time step over an nx*ny grid, with drain between phases.
// Optional FDTD_SWEEP_PERF_EN adds stall/busy-cycle counters.
module fdtd_sweep_ctrl
  import fdtd_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DIM_WIDTH    = 8,
  parameter int STEP_WIDTH   = 16,
  parameter int PIPE_LATENCY = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [DIM_WIDTH-1:0]  nx_i,
  input  logic [DIM_WIDTH-1:0]  ny_i,
  input  logic [STEP_WIDTH-1:0] steps_i,
  input  logic                  rd_gnt_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  phase_o,
  output logic [STEP_WIDTH-1:0] step_o,
  output logic                  rd_req_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic                  wr_phase_o
`ifdef FDTD_SWEEP_PERF_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           cycle_cnt_o
`endif
);

  localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = 1;
  localparam logic [STEP_WIDTH-1:0] STEP_ONE = 1;

  fdtd_state_e           state_q, state_d;
  logic [DIM_WIDTH-1:0]  nx_q, nx_d, ny_q, ny_d;
  logic [DIM_WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic [STEP_WIDTH-1:0] steps_q, steps_d, step_q, step_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic                  phase_q, phase_d;
  logic                  pipe_empty;
  logic                  zero_cfg;
  logic                  start_ok;

  assign zero_cfg = (nx_i == '0) || (ny_i == '0) || (steps_i == '0);
  assign start_ok = (state_q == IDLE) && start_i && !abort_i;

  always_comb begin
    state_d    = state_q;
    nx_d       = nx_q;
    ny_d       = ny_q;
    steps_d    = steps_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    phase_d    = phase_q;
    step_d     = step_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            nx_d       = nx_i;
            ny_d       = ny_i;
            steps_d    = steps_i;
            x_d        = '0;
            y_d        = '0;
            row_base_d = '0;
            phase_d    = PHASE_E;
            step_d     = '0;
            state_d    = zero_cfg ? DONE : RUN;
          end
        end
        RUN: begin
          // Row base advances by nx on wrap so the address never needs a multiply.
          if (rd_gnt_i) begin
            if (x_q == nx_q - DIM_ONE) begin
              x_d = '0;
              if (y_q == ny_q - DIM_ONE) begin
                state_d = DRAIN;
              end else begin
                y_d        = y_q + DIM_ONE;
                row_base_d = row_base_q + ADDR_WIDTH'(nx_q);
              end
            end else begin
              x_d = x_q + DIM_ONE;
            end
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            x_d        = '0;
            y_d        = '0;
            row_base_d = '0;
            if (phase_q == PHASE_E) begin
              phase_d = PHASE_H;
              state_d = RUN;
            end else if (step_q == steps_q - STEP_ONE) begin
              state_d = DONE;
            end else begin
              step_d  = step_q + STEP_ONE;
              phase_d = PHASE_E;
              state_d = RUN;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      nx_q       <= '0;
      ny_q       <= '0;
      steps_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      phase_q    <= PHASE_E;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      nx_q       <= nx_d;
      ny_q       <= ny_d;
      steps_q    <= steps_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      phase_q    <= phase_d;
      step_q     <= step_d;
    end
  end

  // rd_req_o/rd_gnt_i: a read is transferred in any cycle where both are high; rd_addr_o
  // holds while rd_req_o is high without a grant, and a grant with no request is ignored.
  assign rd_req_o  = (state_q == RUN);
  assign rd_addr_o = row_base_q + ADDR_WIDTH'(x_q);
  assign busy_o    = (state_q == RUN) || (state_q == DRAIN);
  assign done_o    = (state_q == DONE);
  assign phase_o   = phase_q;
  assign step_o    = step_q;

  fdtd_valid_pipe #(
    .DEPTH (PIPE_LATENCY),
    .AW    (ADDR_WIDTH)
  ) u_valid_pipe (
    .clk         (CLK),
    .rst_n       (RST_N),
    .flush_i     (abort_i),
    .in_valid_i  (rd_req_o & rd_gnt_i),
    .in_addr_i   (rd_addr_o),
    .in_phase_i  (phase_q),
    .out_valid_o (wr_en_o),
    .out_addr_o  (wr_addr_o),
    .out_phase_o (wr_phase_o),
    .empty_o     (pipe_empty)
  );

`ifdef FDTD_SWEEP_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    if (start_ok) begin
      stall_cnt_d = '0;
      cycle_cnt_d = '0;
    end else begin
      if (busy_o && (cycle_cnt_q != '1)) cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (rd_req_o && !rd_gnt_i && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign cycle_cnt_o = cycle_cnt_q;
`endif

endmodule
